// File: rtl/lock_access_controller.sv
// -----------------------------------------------------------------------------
// lock_access_controller
//
// Sequences multi-digit code entry for the door-lock subsystem. Incoming keypad
// digits are compared one at a time against a programmable code register. A
// correct code opens the lock for a fixed window. Consecutive failures are
// counted, and reaching MAX_FAILS forces a timed lockout. While the lock is
// open, the code can be reprogrammed.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous, active-high reset
//   digit_valid  in   keypad digit present
//   digit        in   keypad digit value [DIGIT_W]
//   digit_ready  out  digit accepted this cycle when digit_valid is high
//   relock       in   force immediate relock from OPEN
//   prog_req     in   request code reprogramming (honoured only in OPEN)
//   unlocked     out  lock open (state OPEN)
//   locked_out   out  lockout active (state LOCKOUT)
//   fail_pulse   out  one-cycle strobe in CHECK on a mismatching code
//   fail_count   out  consecutive failed attempts
//   state_o      out  current state encoding, for status/debug
// -----------------------------------------------------------------------------
module lock_access_controller #(
  parameter int                            DIGIT_W        = 4,
  parameter int                            CODE_LEN       = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0]   DEFAULT_CODE   = 16'h1234,
  parameter int                            MAX_FAILS      = 3,
  parameter int                            OPEN_CYCLES    = 8,
  parameter int                            LOCKOUT_CYCLES = 16,
  parameter int                            ENTRY_TIMEOUT  = 32,
  localparam int                           FC_W           = $clog2(MAX_FAILS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  output logic               digit_ready,
  input  logic               relock,
  input  logic               prog_req,
  output logic               unlocked,
  output logic               locked_out,
  output logic               fail_pulse,
  output logic [FC_W-1:0]    fail_count,
  output logic [2:0]         state_o
);

  localparam int CODE_W  = CODE_LEN * DIGIT_W;
  localparam int IDX_W   = $clog2(CODE_LEN);
  localparam int CNT_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES)
                         ? ((OPEN_CYCLES > ENTRY_TIMEOUT) ? OPEN_CYCLES : ENTRY_TIMEOUT)
                         : ((LOCKOUT_CYCLES > ENTRY_TIMEOUT) ? LOCKOUT_CYCLES : ENTRY_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(ENTRY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CODE_LEN - 1);
  localparam logic [FC_W-1:0]  FC_MAX    = FC_W'(MAX_FAILS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4,
    S_PROG    = 3'd5
  } state_t;

  state_t              r_state,  w_state_nxt;
  logic [CODE_W-1:0]   r_code,   w_code_nxt;
  logic [CODE_W-1:0]   r_shadow, w_shadow_nxt;
  logic [IDX_W-1:0]    r_idx,    w_idx_nxt;
  logic                r_mis,    w_mis_nxt;
  logic [CNT_W-1:0]    r_cnt,    w_cnt_nxt;
  logic [FC_W-1:0]     r_fails,  w_fails_nxt;

  logic                w_accept;
  logic [DIGIT_W-1:0]  w_ref_digit;
  logic [FC_W-1:0]     w_fails_inc;
  logic [CODE_W-1:0]   w_shadow_shift;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_code   <= DEFAULT_CODE;
      r_shadow <= '0;
      r_idx    <= '0;
      r_mis    <= 1'b0;
      r_cnt    <= '0;
      r_fails  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_code   <= w_code_nxt;
      r_shadow <= w_shadow_nxt;
      r_idx    <= w_idx_nxt;
      r_mis    <= w_mis_nxt;
      r_cnt    <= w_cnt_nxt;
      r_fails  <= w_fails_nxt;
    end
  end

  // Stored code digit at the current entry position; the first-entered digit
  // lives in the MSBs of the code register.
  always_comb begin
    w_ref_digit = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_ref_digit = r_code[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign w_accept       = digit_valid && digit_ready;
  assign w_fails_inc    = r_fails + 1'b1;
  assign w_shadow_shift = {r_shadow[CODE_W-DIGIT_W-1:0], digit};

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_code_nxt   = r_code;
    w_shadow_nxt = r_shadow;
    w_idx_nxt    = r_idx;
    w_mis_nxt    = r_mis;
    w_cnt_nxt    = r_cnt;
    w_fails_nxt  = r_fails;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_ENTRY;
          w_idx_nxt   = IDX_W'(1);
          w_mis_nxt   = (digit != r_code[CODE_W-1 -: DIGIT_W]);
          w_cnt_nxt   = '0;
        end
      end

      S_ENTRY: begin
        if (w_accept) begin
          w_mis_nxt = r_mis | (digit != w_ref_digit);
          w_cnt_nxt = '0;
          if (r_idx == IDX_LAST) begin
            w_state_nxt = S_CHECK;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else if (r_cnt == TMO_LAST) begin
          // Abandoned entry: back to idle without counting a failure.
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
          w_mis_nxt   = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_CHECK: begin
        w_idx_nxt = '0;
        w_mis_nxt = 1'b0;
        if (!r_mis) begin
          w_state_nxt = S_OPEN;
          w_fails_nxt = '0;
          w_cnt_nxt   = OPEN_LAST;
        end else begin
          w_fails_nxt = w_fails_inc;
          if (w_fails_inc == FC_MAX) begin
            w_state_nxt = S_LOCKOUT;
            w_cnt_nxt   = LOCK_LAST;
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
      end

      S_OPEN: begin
        // relock beats prog_req; prog_req beats window expiry.
        if (relock) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (prog_req) begin
          w_state_nxt = S_PROG;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      S_LOCKOUT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_fails_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      S_PROG: begin
        if (w_accept) begin
          w_shadow_nxt = w_shadow_shift;
          w_cnt_nxt    = '0;
          if (r_idx == IDX_LAST) begin
            // Only a complete code ever reaches the code register.
            w_code_nxt  = w_shadow_shift;
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else if (r_cnt == TMO_LAST) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
        w_mis_nxt   = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore output decode (fail_pulse also depends on the stored mismatch flag)
  // ---------------------------------------------------------------------------
  assign digit_ready = (r_state == S_IDLE) || (r_state == S_ENTRY) || (r_state == S_PROG);
  assign unlocked    = (r_state == S_OPEN);
  assign locked_out  = (r_state == S_LOCKOUT);
  assign fail_pulse  = (r_state == S_CHECK) && r_mis;
  assign fail_count  = r_fails;
  assign state_o     = r_state;

endmodule

// File: tb/tb_lock_access_controller.sv
module tb_lock_access_controller;

  logic       clk;
  logic       rst;
  logic       digit_valid;
  logic [3:0] digit;
  logic       digit_ready;
  logic       relock;
  logic       prog_req;
  logic       unlocked;
  logic       locked_out;
  logic       fail_pulse;
  logic [1:0] fail_count;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  lock_access_controller dut (
    .clk         (clk),
    .rst         (rst),
    .digit_valid (digit_valid),
    .digit       (digit),
    .digit_ready (digit_ready),
    .relock      (relock),
    .prog_req    (prog_req),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .fail_pulse  (fail_pulse),
    .fail_count  (fail_count),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Expected outputs packed as {state, unlocked, locked_out, fail_pulse, fail_count, digit_ready}
  typedef struct {
    string      nm;
    logic [8:0] exp;
  } sb_t;

  sb_t sbq[$];

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       rl;
    logic       pr;
    logic [2:0] st;
    logic       fp;
    logic [1:0] fc;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mkv(input logic v, input logic [3:0] d, input logic [2:0] st,
                               input logic fp, input logic [1:0] fc);
    vec_t r;
    r.v  = v;
    r.d  = d;
    r.rl = 1'b0;
    r.pr = 1'b0;
    r.st = st;
    r.fp = fp;
    r.fc = fc;
    return r;
  endfunction

  function automatic logic [8:0] expo(input logic [2:0] st, input logic fp, input logic [1:0] fc);
    logic unl;
    logic lo;
    logic rdy;
    unl = (st == 3'd3);
    lo  = (st == 3'd4);
    rdy = (st == 3'd0) || (st == 3'd1) || (st == 3'd5);
    return {st, unl, lo, fp, fc, rdy};
  endfunction

  task automatic push_exp(input string nm, input logic [2:0] st, input logic fp, input logic [1:0] fc);
    sb_t e;
    e.nm  = nm;
    e.exp = expo(st, fp, fc);
    sbq.push_back(e);
  endtask

  task automatic check_pop();
    sb_t        e;
    logic [8:0] act;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got no expected entry, required one");
    end else begin
      e   = sbq.pop_front();
      act = {state_o, unlocked, locked_out, fail_pulse, fail_count, digit_ready};
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %b required %b (state,unl,lo,fp,fc,rdy)", e.nm, act, e.exp);
      end
    end
  endtask

  // Drive one cycle of inputs, then compare outputs 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [3:0] d, input logic rl, input logic pr,
                     input logic [2:0] st, input logic fp, input logic [1:0] fc, input string nm);
    digit_valid = v;
    digit       = d;
    relock      = rl;
    prog_req    = pr;
    push_exp(nm, st, fp, fc);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  // Four digits on consecutive cycles; st_mid after digits 1-3, st_last after digit 4.
  task automatic enter(input logic [15:0] code, input logic [2:0] st_mid, input logic [2:0] st_last,
                       input logic fp_last, input logic [1:0] fc, input string nm);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, code[15-4*i -: 4], 1'b0, 1'b0,
          (i == 3) ? st_last : st_mid, (i == 3) ? fp_last : 1'b0, fc, nm);
    end
  endtask

  // Asynchronous reset mid-cycle: outputs must reach reset values before the next edge.
  task automatic reset_pulse(input string nm);
    digit_valid = 1'b0;
    relock      = 1'b0;
    prog_req    = 1'b0;
    rst         = 1'b1;
    #2;
    push_exp(nm, 3'd0, 1'b0, 2'd0);
    check_pop();
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    digit_valid = 1'b0;
    digit       = 4'd0;
    relock      = 1'b0;
    prog_req    = 1'b0;
    #3;
    push_exp("reset_state", 3'd0, 1'b0, 2'd0);
    check_pop();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Test 1: correct code, open window of exactly 8 cycles, then idle
    tbl[0] = mkv(1'b1, 4'd1, 3'd1, 1'b0, 2'd0);
    tbl[1] = mkv(1'b1, 4'd2, 3'd1, 1'b0, 2'd0);
    tbl[2] = mkv(1'b1, 4'd3, 3'd1, 1'b0, 2'd0);
    tbl[3] = mkv(1'b1, 4'd4, 3'd2, 1'b0, 2'd0);
    for (int i = 4; i < 12; i++) tbl[i] = mkv(1'b0, 4'd0, 3'd3, 1'b0, 2'd0);
    tbl[12] = mkv(1'b0, 4'd0, 3'd0, 1'b0, 2'd0);
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].rl, tbl[i].pr, tbl[i].st, tbl[i].fp, tbl[i].fc, "t1_vec");
    end

    // Test 2: three wrong codes -> lockout for 16 cycles, digits ignored
    enter(16'h1235, 3'd1, 3'd2, 1'b1, 2'd0, "t2_att1");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd1, "t2_after1");
    enter(16'h1235, 3'd1, 3'd2, 1'b1, 2'd1, "t2_att2");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd2, "t2_after2");
    enter(16'h1235, 3'd1, 3'd2, 1'b1, 2'd2, "t2_att3");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd4, 1'b0, 2'd3, "t2_lockout_start");
    for (int i = 0; i < 15; i++) cyc(1'b1, 4'd1, 1'b0, 1'b0, 3'd4, 1'b0, 2'd3, "t2_lockout_hold");
    cyc(1'b1, 4'd1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, "t2_lockout_exit");

    // Test 3: two failures then success clears count; a later failure does not lock out
    enter(16'h1235, 3'd1, 3'd2, 1'b1, 2'd0, "t3_bad1");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd1, "t3_after1");
    enter(16'h1235, 3'd1, 3'd2, 1'b1, 2'd1, "t3_bad2");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd2, "t3_after2");
    enter(16'h1234, 3'd1, 3'd2, 1'b0, 2'd2, "t3_good");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd3, 1'b0, 2'd0, "t3_open_clear");
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 3'd0, 1'b0, 2'd0, "t3_relock");
    enter(16'h1111, 3'd1, 3'd2, 1'b1, 2'd0, "t3_bad3");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd1, "t3_no_lockout");

    // Test 4: reprogram to 9876, old code fails, new code opens, reset restores 1234
    enter(16'h1234, 3'd1, 3'd2, 1'b0, 2'd1, "t4_unlock");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd3, 1'b0, 2'd0, "t4_open1");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd3, 1'b0, 2'd0, "t4_open2");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd3, 1'b0, 2'd0, "t4_open3");
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 3'd5, 1'b0, 2'd0, "t4_prog");
    enter(16'h9876, 3'd5, 3'd0, 1'b0, 2'd0, "t4_program");
    enter(16'h1234, 3'd1, 3'd2, 1'b1, 2'd0, "t4_old_code");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd1, "t4_old_fails");
    enter(16'h9876, 3'd1, 3'd2, 1'b0, 2'd1, "t4_new_code");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd3, 1'b0, 2'd0, "t4_new_opens");
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 3'd0, 1'b0, 2'd0, "t4_relock");
    reset_pulse("t4_reset");
    enter(16'h1234, 3'd1, 3'd2, 1'b0, 2'd0, "t4_default_back");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd3, 1'b0, 2'd0, "t4_default_opens");
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 3'd0, 1'b0, 2'd0, "t4_relock2");

    // Test 5: entry timeout keeps fail_count; partial programming is discarded
    enter(16'h5555, 3'd1, 3'd2, 1'b1, 2'd0, "t5_bad");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd1, "t5_after_bad");
    cyc(1'b1, 4'd1, 1'b0, 1'b0, 3'd1, 1'b0, 2'd1, "t5_partial");
    cyc(1'b1, 4'd2, 1'b0, 1'b0, 3'd1, 1'b0, 2'd1, "t5_partial");
    for (int i = 0; i < 31; i++) cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd1, 1'b0, 2'd1, "t5_entry_wait");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd1, "t5_entry_timeout");
    enter(16'h1234, 3'd1, 3'd2, 1'b0, 2'd1, "t5_unlock");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd3, 1'b0, 2'd0, "t5_open");
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 3'd5, 1'b0, 2'd0, "t5_prog");
    cyc(1'b1, 4'd9, 1'b0, 1'b0, 3'd5, 1'b0, 2'd0, "t5_prog_digit");
    cyc(1'b1, 4'd8, 1'b0, 1'b0, 3'd5, 1'b0, 2'd0, "t5_prog_digit");
    for (int i = 0; i < 31; i++) cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd5, 1'b0, 2'd0, "t5_prog_wait");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, "t5_prog_timeout");
    enter(16'h1234, 3'd1, 3'd2, 1'b0, 2'd0, "t5_code_kept");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd3, 1'b0, 2'd0, "t5_code_kept_open");

    // Test 6: relock beats prog_req; prog_req at window expiry; async reset mid-entry
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 3'd0, 1'b0, 2'd0, "t6_relock_priority");
    enter(16'h1234, 3'd1, 3'd2, 1'b0, 2'd0, "t6_unlock");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd3, 1'b0, 2'd0, "t6_open1");
    for (int i = 0; i < 7; i++) cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd3, 1'b0, 2'd0, "t6_open_rest");
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 3'd5, 1'b0, 2'd0, "t6_prog_at_expiry");
    enter(16'h1234, 3'd5, 3'd0, 1'b0, 2'd0, "t6_reprogram");
    cyc(1'b1, 4'd1, 1'b0, 1'b0, 3'd1, 1'b0, 2'd0, "t6_entry");
    cyc(1'b1, 4'd2, 1'b0, 1'b0, 3'd1, 1'b0, 2'd0, "t6_entry");
    reset_pulse("t6_async_reset");
    enter(16'h1234, 3'd1, 3'd2, 1'b0, 2'd0, "t6_after_reset");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 3'd3, 1'b0, 2'd0, "t6_after_reset_open");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
